// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - IFU/datapath control bundle driven by mc_ctrl
interface mc_ctrl_if #(parameter int RET_W = 32);
  logic [31:0]      instr;
  logic             zero;
  logic             pc_we;
  logic [1:0]       npc_sel;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             alu_src;
  logic             ext_op;
  logic [1:0]       alu_op;
  logic             mem_we;
  logic [2:0]       state;
  logic             halted;
  logic [RET_W-1:0] retired;

  modport master (
    input  instr, zero,
    output pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op,
           alu_op, mem_we, state, halted, retired
  );

  modport slave (
    output instr, zero,
    input  pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, ext_op,
           alu_op, mem_we, state, halted, retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB/HALT)
module mc_ctrl #(
  parameter int RET_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master mc
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_BAD
  } kind_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [RET_W-1:0] retired_q;
  logic             halted_q;
  kind_t            kind;
  logic             terminal;

  logic       pc_we_c, reg_we_c, mem_we_c, alu_src_c, ext_op_c;
  logic [1:0] npc_sel_c, reg_dst_c, wd_sel_c, alu_op_c;

  always_comb begin
    kind = I_BAD;
    case (ir_q[31:26])
      6'h00: begin
        if (ir_q == 32'd0)           kind = I_NOP;
        else if (ir_q[5:0] == 6'h21) kind = I_ADDU;
        else if (ir_q[5:0] == 6'h23) kind = I_SUBU;
        else if (ir_q[5:0] == 6'h08) kind = I_JR;
        else                         kind = I_BAD;
      end
      6'h0d:   kind = I_ORI;
      6'h0f:   kind = I_LUI;
      6'h23:   kind = I_LW;
      6'h2b:   kind = I_SW;
      6'h04:   kind = I_BEQ;
      6'h02:   kind = I_J;
      6'h03:   kind = I_JAL;
      default: kind = I_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) ir_q <= mc.instr;
      if (terminal) retired_q <= retired_q + 1'b1;
      if (state_q == DECODE && kind == I_BAD) halted_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (kind)
          I_NOP, I_J, I_JR: state_d = FETCH;
          I_JAL:            state_d = WB;
          I_BAD:            state_d = HALT;
          default:          state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (kind)
          I_BEQ:      state_d = FETCH;
          I_LW, I_SW: state_d = MEM;
          default:    state_d = WB;
        endcase
      end
      MEM:     state_d = (kind == I_SW) ? FETCH : WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its last working state.
  assign terminal = (state_q inside {DECODE, EXEC, MEM, WB}) && (state_d == FETCH);

  always_comb begin
    pc_we_c   = 1'b0;
    npc_sel_c = 2'b00;
    reg_we_c  = 1'b0;
    reg_dst_c = 2'b00;
    wd_sel_c  = 2'b00;
    alu_src_c = 1'b0;
    ext_op_c  = 1'b0;
    alu_op_c  = 2'b00;
    mem_we_c  = 1'b0;
    case (state_q)
      DECODE: begin
        case (kind)
          I_NOP:   pc_we_c = 1'b1;
          I_J:     begin pc_we_c = 1'b1; npc_sel_c = 2'b10; end
          I_JR:    begin pc_we_c = 1'b1; npc_sel_c = 2'b01; end
          default: ;
        endcase
      end
      EXEC: begin
        case (kind)
          I_SUBU:     alu_op_c = 2'b01;
          I_ORI:      begin alu_src_c = 1'b1; alu_op_c = 2'b10; end
          I_LW, I_SW: begin alu_src_c = 1'b1; ext_op_c = 1'b1; end
          I_BEQ: begin
            alu_op_c  = 2'b01;
            pc_we_c   = 1'b1;
            npc_sel_c = mc.zero ? 2'b11 : 2'b00;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (kind == I_SW) begin
          mem_we_c = 1'b1;
          pc_we_c  = 1'b1;
        end
      end
      WB: begin
        pc_we_c  = 1'b1;
        reg_we_c = 1'b1;
        case (kind)
          I_ADDU, I_SUBU: reg_dst_c = 2'b01;
          I_LUI:          wd_sel_c  = 2'b11;
          I_LW:           wd_sel_c  = 2'b01;
          I_JAL: begin
            reg_dst_c = 2'b10;
            wd_sel_c  = 2'b10;
            npc_sel_c = 2'b10;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Write enables are forced low for as long as reset is held, independent of state.
  assign mc.pc_we   = pc_we_c & reset;
  assign mc.reg_we  = reg_we_c & reset;
  assign mc.mem_we  = mem_we_c & reset;
  assign mc.npc_sel = npc_sel_c;
  assign mc.reg_dst = reg_dst_c;
  assign mc.wd_sel  = wd_sel_c;
  assign mc.alu_src = alu_src_c;
  assign mc.ext_op  = ext_op_c;
  assign mc.alu_op  = alu_op_c;
  assign mc.state   = state_q;
  assign mc.halted  = halted_q;
  assign mc.retired = retired_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS core.
- Sequences the IFU (PC write enable plus 2-bit NPC select), the GRF, the ALU/EXT and the DM, one instruction at a time.
- Latches the fetched word in an internal IR, walks a FETCH/DECODE/EXEC/MEM/WB state machine, and asserts exactly one PC write per retired instruction.
- Sits between the IFU and the datapath muxes; owns all write enables.

Parameters:
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  IFU instruction output; sampled only in FETCH.
- zero  in  1  ALU equality flag (rs==rt), valid in EXEC.
- pc_we  out  1  IFU PC write enable.
- npc_sel  out  2  IFU next-PC select:
  - 00 = PC+4
  - 01 = register (jr)
  - 10 = j/jal target
  - 11 = beq target
- reg_we  out  1  GRF write enable.
- reg_dst  out  2  GRF write address: 00 rt, 01 rd, 10 $31.
- wd_sel  out  2  GRF write data: 00 ALU, 01 DM, 10 PC+4, 11 imm<<16.
- alu_src  out  1  ALU B operand: 0 register, 1 extended immediate.
- ext_op  out  1  0 zero-extend, 1 sign-extend.
- alu_op  out  2  00 add, 01 sub, 10 or.
- mem_we  out  1  DM write enable.
- state  out  3  current state (debug).
- halted  out  1  illegal opcode seen; sticky.
- retired  out  RET_W  count of retired instructions.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (reset=0, async) forces:
  - state=FETCH, IR=0, retired=0, halted=0.
  - All write enables (pc_we, reg_we, mem_we) held 0 while reset is low, regardless of state.
  - Reset asserted mid-instruction abandons it with no partial write.
- FETCH: IR<=instr at the clock edge; always go to DECODE.
- Outputs are Moore functions of state and IR. Non-listed outputs are 0 in every state.
- Instruction paths and terminal-state outputs:
  - nop (IR==0): DECODE is terminal; pc_we=1, npc_sel=00.
  - addu (op 0, funct 0x21) / subu (funct 0x23): D->E->WB. EXEC alu_op=00/01. WB reg_we=1, reg_dst=01, wd_sel=00, pc_we=1, npc_sel=00.
  - ori (0x0d): D->E->WB. alu_src=1, ext_op=0, alu_op=10. WB reg_dst=00.
  - lui (0x0f): D->E->WB. WB wd_sel=11, reg_dst=00.
  - lw (0x23): D->E->M->WB. EXEC alu_src=1, ext_op=1, alu_op=00. WB wd_sel=01, reg_dst=00.
  - sw (0x2b): D->E->M. MEM is terminal with mem_we=1, pc_we=1, npc_sel=00.
  - beq (0x04): D->E. EXEC alu_op=01 and is terminal: pc_we=1, npc_sel=11 if zero else 00.
  - j (0x02): DECODE terminal; pc_we=1, npc_sel=10.
  - jal (0x03): D->WB. WB reg_we=1, reg_dst=10, wd_sel=10, pc_we=1, npc_sel=10.
  - jr (op 0, funct 0x08): DECODE terminal; pc_we=1, npc_sel=01.
- Terminal state:
  - Next state is FETCH.
  - retired increments by 1 on the same edge; wraps to 0 at 2^RET_W.
  - pc_we is never 1 in FETCH. The IFU output is therefore stable when sampled.
- Any other opcode/funct in DECODE:
  - halted<=1, go to HALT.
  - HALT holds all enables 0 and does not self-exit; only reset clears it.
- CPI: nop/j/jr 2; beq 3; jal 3; addu/subu/ori/lui 4; sw 4; lw 5.

Test Plan:
- Reset low mid-EXEC of addu -> state=0, pc_we=reg_we=mem_we=0 immediately. After release, FETCH samples instr at PC 0x00003000; retired=0.
- Stream addu, ori, lw, sw, then nop -> terminal pc_we pulses at cycles 4, 8, 13, 17, 19 after release. retired=5. Per-state mux outputs match the Behaviour table.
- beq with zero=1 -> EXEC pc_we=1, npc_sel=11. Same beq with zero=0 -> npc_sel=00. Each takes 3 cycles.
- jal then jr -> jal WB: reg_dst=10, wd_sel=10, npc_sel=10. jr DECODE: npc_sel=01. FETCH never shows pc_we=1.
- Opcode 0x3f -> halted=1, state=5, no pc_we for 20 cycles. Reset low then high -> halted=0, FETCH.
- Preload retired=2^RET_W-1 (force), retire one nop -> retired=0.
